// File: rtl/car_park_pkg.sv
// Shared definitions for the car park slice: slot geometry, lift timing and
// the FSM state encoding used by the storage manager and the select-car
// controller.
package car_park_pkg;

    localparam int NUM_SLOTS   = 24;   // number of parking slots
    localparam int ADDR_W      = 5;    // slot address width
    localparam int MOVE_CYCLES = 100;  // clock cycles per lift move (>= 1)
    localparam int CNT_W       = 8;    // move-timer width, 2**CNT_W > MOVE_CYCLES

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MOVE_IN  = 2'd1,
        MOVE_OUT = 2'd2,
        COMMIT   = 2'd3
    } park_state_t;

endpackage

// File: rtl/free_slot_finder.sv
// Combinational priority encoder that finds the lowest free parking slot.
// Ports:
//   car_storage      in   occupancy bitmap, bit i = 1 means slot i occupied
//   found            out  at least one slot is free
//   lowest_free_addr out  index of the lowest free slot (0 when none found)
module free_slot_finder #(
    parameter int NUM_SLOTS = car_park_pkg::NUM_SLOTS,
    parameter int ADDR_W    = car_park_pkg::ADDR_W
) (
    input  logic [NUM_SLOTS-1:0] car_storage,
    output logic                 found,
    output logic [ADDR_W-1:0]    lowest_free_addr
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        found            = 1'b0;
        lowest_free_addr = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!car_storage[i]) begin
                found            = 1'b1;
                lowest_free_addr = ADDR_W'(i);
            end
        end
    end

endmodule

// File: rtl/car_storage_manager.sv
// Owns the slot occupancy bitmap. Park requests auto-allocate the lowest free
// slot, retrieve requests free the addressed slot; each accepted request runs
// a timed lift move and the bitmap is committed only when the move finishes.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-low reset
//   park_req        pulse: park an incoming car
//   retrieve_req    pulse: retrieve the car at retrieve_addr
//   retrieve_addr   slot to retrieve
//   car_storage     registered occupancy bitmap
//   car_count       registered number of occupied slots
//   full, empty     decoded from car_count
//   busy            lift move in progress
//   target_addr     slot being serviced, holds while idle
//   done            one-cycle pulse when a move commits
//   reject          one-cycle pulse when a request is refused
module car_storage_manager #(
    parameter int NUM_SLOTS   = car_park_pkg::NUM_SLOTS,
    parameter int ADDR_W      = car_park_pkg::ADDR_W,
    parameter int MOVE_CYCLES = car_park_pkg::MOVE_CYCLES,
    parameter int CNT_W       = car_park_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 park_req,
    input  logic                 retrieve_req,
    input  logic [ADDR_W-1:0]    retrieve_addr,
    output logic [NUM_SLOTS-1:0] car_storage,
    output logic [ADDR_W-1:0]    car_count,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic [ADDR_W-1:0]    target_addr,
    output logic                 done,
    output logic                 reject
);
    import car_park_pkg::*;

    // The bitmap is widened to the full address space so that indexing with
    // any address is always in range; the extra bits read as unoccupied.
    localparam int                WIDE_W  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   SLOTS_A = (ADDR_W + 1)'(NUM_SLOTS);

    park_state_t           state_reg,   state_next;
    logic [CNT_W-1:0]      timer_reg,   timer_next;
    logic [NUM_SLOTS-1:0]  storage_reg, storage_next;
    logic [ADDR_W-1:0]     count_reg,   count_next;
    logic [ADDR_W-1:0]     target_reg,  target_next;
    logic                  done_reg,    done_next;
    logic                  reject_reg,  reject_next;

    logic [WIDE_W-1:0]     storage_wide;
    logic [WIDE_W-1:0]     storage_upd;
    logic                  slot_found;
    logic [ADDR_W-1:0]     free_addr;
    logic                  retrieve_ok;
    logic                  is_full;

    free_slot_finder #(
        .NUM_SLOTS (NUM_SLOTS),
        .ADDR_W    (ADDR_W)
    ) u_free_slot_finder (
        .car_storage      (storage_reg),
        .found            (slot_found),
        .lowest_free_addr (free_addr)
    );

    assign is_full      = (count_reg == ADDR_W'(NUM_SLOTS));
    assign storage_wide = WIDE_W'(storage_reg);
    assign retrieve_ok  = retrieve_req && ({1'b0, retrieve_addr} < SLOTS_A)
                          && storage_wide[retrieve_addr];

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        storage_next = storage_reg;
        count_next   = count_reg;
        target_next  = target_reg;
        done_next    = 1'b0;
        reject_next  = 1'b0;
        storage_upd  = storage_wide;

        case (state_reg)
            IDLE: begin
                if (retrieve_ok) begin
                    // A simultaneous park is dropped and reported as refused.
                    target_next = retrieve_addr;
                    timer_next  = CNT_W'(MOVE_CYCLES - 1);
                    state_next  = MOVE_OUT;
                    reject_next = park_req;
                end else if (park_req && !is_full && slot_found) begin
                    // A refused retrieve in the same cycle still reports reject.
                    target_next = free_addr;
                    timer_next  = CNT_W'(MOVE_CYCLES - 1);
                    state_next  = MOVE_IN;
                    reject_next = retrieve_req;
                end else begin
                    reject_next = park_req | retrieve_req;
                end
            end
            MOVE_IN, MOVE_OUT: begin
                reject_next = park_req | retrieve_req;
                if (timer_reg == '0) begin
                    // Occupancy lands on the edge entering COMMIT so that it
                    // is visible together with done during the COMMIT cycle.
                    storage_upd[target_reg] = (state_reg == MOVE_IN);
                    storage_next = storage_upd[NUM_SLOTS-1:0];
                    count_next   = (state_reg == MOVE_IN) ? count_reg + 1'b1
                                                          : count_reg - 1'b1;
                    done_next    = 1'b1;
                    state_next   = COMMIT;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            COMMIT: begin
                reject_next = park_req | retrieve_req;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            storage_reg <= '0;
            count_reg   <= '0;
            target_reg  <= '0;
            done_reg    <= 1'b0;
            reject_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            storage_reg <= storage_next;
            count_reg   <= count_next;
            target_reg  <= target_next;
            done_reg    <= done_next;
            reject_reg  <= reject_next;
        end
    end

    assign car_storage = storage_reg;
    assign car_count   = count_reg;
    assign full        = is_full;
    assign empty       = (count_reg == '0);
    assign busy        = (state_reg == MOVE_IN) || (state_reg == MOVE_OUT);
    assign target_addr = target_reg;
    assign done        = done_reg;
    assign reject      = reject_reg;

endmodule

// File: tb/tb_car_storage_manager.sv
module tb_car_storage_manager;

    localparam int MC = 4;   // lift move length used by this bench
    localparam int NS = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        park_req = 1'b0;
    logic        retrieve_req = 1'b0;
    logic [4:0]  retrieve_addr = '0;
    logic [23:0] car_storage;
    logic [4:0]  car_count;
    logic        full, empty, busy, done, reject;
    logic [4:0]  target_addr;

    int checks = 0;
    int failures = 0;

    // reference model: set of occupied slots
    logic [23:0] model_bm = '0;

    always #5 clk = ~clk;

    car_storage_manager #(.MOVE_CYCLES(MC)) dut (
        .clk           (clk),
        .rst           (rst),
        .park_req      (park_req),
        .retrieve_req  (retrieve_req),
        .retrieve_addr (retrieve_addr),
        .car_storage   (car_storage),
        .car_count     (car_count),
        .full          (full),
        .empty         (empty),
        .busy          (busy),
        .target_addr   (target_addr),
        .done          (done),
        .reject        (reject)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int popcount(input logic [23:0] v);
        int n = 0;
        for (int i = 0; i < NS; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int lowest_free(input logic [23:0] v);
        for (int i = 0; i < NS; i++) if (!v[i]) return i;
        return -1;
    endfunction

    // Issue one request from idle and follow it through to completion.
    // inject: drive a stray park_req during the move, which must be refused.
    task automatic do_request(input logic park, input logic retr, input int addr,
                              input logic inject);
        logic ret_ok, park_ok, accepted, exp_rej;
        int   exp_target, busy_cnt, done_cyc, inj_rej;
        ret_ok     = retr && addr < NS && model_bm[addr];
        park_ok    = !ret_ok && park && popcount(model_bm) < NS;
        accepted   = ret_ok || park_ok;
        exp_rej    = (retr && !ret_ok) || (park && !park_ok);
        exp_target = ret_ok ? addr : lowest_free(model_bm);
        busy_cnt = 0; done_cyc = 0; inj_rej = 0;

        @(negedge clk);
        park_req = park; retrieve_req = retr; retrieve_addr = 5'(addr);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                park_req = 1'b0; retrieve_req = 1'b0;
                retrieve_addr = 5'($urandom_range(31));
                check("req_reject", reject, exp_rej);
                check("req_busy", busy, accepted);
                if (accepted) check("req_target", target_addr, exp_target);
                if (!accepted) begin
                    check("refused_bitmap", car_storage, model_bm);
                    break;
                end
            end
            if (busy) busy_cnt++;
            if (inject && c == 2) park_req = 1'b1;
            if (inject && c == 3) begin
                park_req = 1'b0;
                inj_rej = int'(reject);
            end
            if (c < MC + 1) check("early_bitmap", car_storage, model_bm);
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        if (accepted) begin
            if (ret_ok) model_bm[addr] = 1'b0;
            else        model_bm[exp_target] = 1'b1;
            check("busy_cycles", busy_cnt, MC);
            check("done_cycle", done_cyc, MC + 1);
            check("commit_bitmap", car_storage, model_bm);
            check("commit_count", car_count, popcount(model_bm));
            check("commit_full", full, popcount(model_bm) == NS);
            check("commit_empty", empty, popcount(model_bm) == 0);
            check("commit_busy", busy, 0);
            if (inject) check("inject_reject", inj_rej, 1);
            @(negedge clk);
            check("after_done", done, 0);
            check("after_busy", busy, 0);
        end
        $display("txn park=%0d retr=%0d addr=%0d acc=%0d bitmap=%06h count=%0d",
                 park, retr, addr, accepted, car_storage, car_count);
    endtask

    initial begin
        int a;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bitmap", car_storage, 0);
        check("rst_count", car_count, 0);
        check("rst_busy", busy, 0);
        check("rst_empty", empty, 1);
        check("rst_target", target_addr, 0);
        rst = 1'b1;

        // three parks -> slots 0,1,2
        for (int k = 0; k < 3; k++) do_request(1, 0, 0, 0);
        check("three_parks", car_storage, 24'h000007);
        // retrieve slot 1, then park refills it
        do_request(0, 1, 1, 0);
        check("retrieve1", car_storage, 24'h000005);
        do_request(1, 0, 0, 0);
        check("refill_target", target_addr, 1);
        // refusals
        do_request(0, 1, 5, 0);
        do_request(0, 1, 30, 0);
        // contention: retrieve wins, park rejected
        do_request(1, 1, 0, 0);
        // stray park during a move
        do_request(1, 0, 0, 1);
        // fill up then park while full
        while (popcount(model_bm) < NS) do_request(1, 0, 0, 0);
        check("full_flag", full, 1);
        do_request(1, 0, 0, 0);
        check("full_bitmap", car_storage, 24'hFFFFFF);

        // randomized traffic
        for (int k = 0; k < 120; k++) begin
            a = ($urandom_range(3) == 0) ? int'($urandom_range(31)) : int'($urandom_range(23));
            case ($urandom_range(3))
                0: do_request(1, 0, 0, $urandom_range(3) == 0);
                1, 2: do_request(0, 1, a, $urandom_range(3) == 0);
                default: do_request(1, 1, a, 0);
            endcase
        end

        // reset two cycles into a move
        while (popcount(model_bm) == NS) do_request(0, 1, int'($urandom_range(23)), 0);
        @(negedge clk);
        park_req = 1'b1;
        @(negedge clk);
        park_req = 1'b0;
        check("pre_reset_busy", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_bm = '0;
        check("mid_rst_bitmap", car_storage, 0);
        check("mid_rst_count", car_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_target", target_addr, 0);
        check("mid_rst_done", done, 0);
        rst = 1'b1;
        a = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a += int'(done) + int'(busy);
        end
        check("no_done_after_rst", a, 0);
        do_request(1, 0, 0, 0);
        check("post_rst_target", target_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/car_storage_manager.md
Name: car_storage_manager

Overview:
- Owns the 24-slot occupancy bitmap `car_storage` that the select-car controller browses. It is the upstream stage feeding that controller.
- Accepts park requests, which auto-allocate the lowest free slot, and retrieve requests for the slot currently selected.
- Sequences a timed lift move for each accepted request and commits the occupancy change only when the move completes.

Parameters:
- NUM_SLOTS, 24, number of parking slots; width of `car_storage`.
- ADDR_W, 5, slot address width.
- MOVE_CYCLES, 100, clock cycles one lift move takes; must be 1 or more.
- CNT_W, 8, width of the move-timer counter; must satisfy 2^CNT_W > MOVE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- park_req  in  1  single-cycle pulse: park an incoming car.
- retrieve_req  in  1  single-cycle pulse: retrieve the car at retrieve_addr.
- retrieve_addr  in  ADDR_W  slot to retrieve; driven from the select controller's current_addr.
- car_storage  out  NUM_SLOTS  occupancy bitmap, registered; bit i = 1 means slot i is occupied.
- car_count  out  ADDR_W  number of occupied slots, registered.
- full  out  1  car_count == NUM_SLOTS, combinational from the register.
- empty  out  1  car_count == 0, combinational from the register.
- busy  out  1  lift move in progress.
- target_addr  out  ADDR_W  slot being serviced; holds its last value while idle.
- done  out  1  one-cycle pulse on commit.
- reject  out  1  one-cycle pulse when a request is refused.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst == 0 at a clk edge):
  - car_storage = 0, car_count = 0, target_addr = 0.
  - busy = 0, done = 0, reject = 0; FSM returns to IDLE and the timer is cleared.
  - Reset mid-move aborts the move with no commit and no done pulse.
- FSM states: IDLE, MOVE_IN, MOVE_OUT, COMMIT.
- IDLE:
  - retrieve_req has priority over park_req when both are asserted in the same cycle.
  - A retrieve is accepted when retrieve_addr < NUM_SLOTS and car_storage[retrieve_addr] == 1. Then target_addr = retrieve_addr, timer = MOVE_CYCLES-1, next state MOVE_OUT.
  - Retrieve with an out-of-range address or an empty slot: reject pulses next cycle, state stays IDLE.
  - Simultaneous park and retrieve: if the retrieve is accepted, the park is dropped and reject pulses. If the retrieve is refused, the park is evaluated normally.
  - A park is accepted when !full. Then target_addr = lowest index i with car_storage[i] == 0, timer = MOVE_CYCLES-1, next state MOVE_IN.
  - Park while full: reject pulses, state stays IDLE.
- MOVE_IN / MOVE_OUT:
  - busy = 1. The timer decrements each cycle; when the timer == 0, next state is COMMIT.
  - Any park_req or retrieve_req during this time is refused with a reject pulse and is not queued.
  - The retrieve_addr input is ignored; the latched target_addr is used.
- COMMIT (one cycle):
  - Registered results: the car_storage[target_addr] bit is set (IN) or cleared (OUT), car_count is incremented or decremented, and done = 1.
  - busy = 0 in this cycle; next state IDLE.
  - A request arriving in this cycle is refused with a reject pulse.
- Latency: request sampled at edge E. busy is high for MOVE_CYCLES cycles starting at E+1. The bitmap update and done pulse appear at E+MOVE_CYCLES+1. The earliest next request is accepted at E+MOVE_CYCLES+2.
- Invariants:
  - car_count always equals popcount(car_storage).
  - The bitmap changes only in COMMIT.
  - Bits at index NUM_SLOTS and above do not exist.
- Wrap-around: none. The count saturates naturally because of the full and empty guards.

Decomposition:
- Shared package/include `car_park_pkg` holds NUM_SLOTS, ADDR_W, the FSM state encodings (2 bits: IDLE = 0, MOVE_IN = 1, MOVE_OUT = 2, COMMIT = 3) and MOVE_CYCLES. The select-car controller uses the same package.
- One sub-module, `free_slot_finder`: combinational priority encoder from car_storage to {found, lowest_free_addr}. Index 0 has the highest priority.

Test Plan (MOVE_CYCLES = 4):
- Reset, then park_req ×3 with each pulse issued after the previous done:
  - Each request: busy for 4 cycles, done at E+5.
  - Final state: car_storage = 24'h000007, car_count = 3, target_addr sequence 0, 1, 2.
- Bitmap 24'h000007; retrieve_req with addr 1:
  - busy for 4 cycles; at E+5, car_storage = 24'h000005 and car_count = 2.
  - A following park_req gets target_addr = 1, and the final bitmap is 24'h000007.
- Refusals:
  - retrieve_req with addr 5 on an empty slot → reject at E+1, no busy.
  - retrieve_req with addr 30 → reject.
  - park_req with 24'hFFFFFF stored (full = 1) → reject, bitmap unchanged.
- Contention:
  - park_req and retrieve_req (addr 0, occupied) together → MOVE_OUT selected and reject pulses.
  - park_req during busy → reject, and no extra move follows done.
- Reset mid-move:
  - Assert rst = 0 two cycles into MOVE_IN → all outputs 0 at the next edge, and no done pulse.
  - After release, a park_req gets target_addr = 0.
